ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Execute-to-memory pipeline stage of the RV32I core. It sits directly downstream of the ALU and consumes `ALUResult` and `zero`. It resolves branches and jumps into a one-cycle registered PC redirect, and formats store data and byte enables. It also checks address alignment and registers everything into the EX/MEM boundary under a valid/ready handshake with stall and wrong-path squash.

## Interface
- `XLEN`, 32, datapath width (only 32 supported)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `ex_valid`  in  1  EX holds a valid instruction
- `ex_ready`  out  1  stage can accept this cycle
- `ex_pc`, `ex_imm`  in  32  instruction PC, sign-extended immediate
- `ex_alu_result`  in  32  ALU `ALUResult` (address for loads/stores/JALR, value otherwise)
- `ex_zero`  in  1  ALU `zero`; already encodes the branch condition via `equalComp`
- `ex_rs2_data`  in  32  store source
- `ex_rd`  in  5; `ex_funct3`  in  3
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch`, `ex_jal`, `ex_jalr`  in  1 each
- `mem_stall`  in  1  MEM stage cannot consume this cycle
- `redirect`  out  1  one-cycle pulse: fetch must load `redirect_pc` and flush younger stages
- `redirect_pc`  out  32
- `mem_valid`  out  1; `mem_pc`, `mem_result`, `mem_wdata`  out  32
- `mem_be`  out  4; `mem_rd`  out  5; `mem_funct3`  out  3
- `mem_reg_write`, `mem_mem_read`, `mem_mem_write`  out  1
- `mem_exc`  out  1; `mem_exc_cause`  out  2  (01 instr-misaligned, 10 load-misaligned, 11 store-misaligned)

## Operation
- `ex_ready = ~mem_valid | ~mem_stall`.
- Capture occurs when `ex_valid & ex_ready & ~redirect`.
- If `ex_valid & ex_ready & redirect`, the instruction is wrong-path. It is accepted and discarded: no capture, no side effects.
- `taken = (ex_branch & ex_zero) | ex_jal | ex_jalr`.
- Target:
  - branch and JAL: `ex_pc + ex_imm` (mod 2^32);
  - JALR: `ex_alu_result & ~32'h1`.
- `mem_result`:
  - JAL/JALR: `ex_pc + 4`;
  - otherwise: `ex_alu_result`.
- Let `a = ex_alu_result[1:0]`. Stores replicate the data; store and load byte enables and alignment:
  - byte (funct3 x00): wdata = {4{rs2[7:0]}}, be = 4'b0001 << a, never misaligned.
  - half (x01): wdata = {2{rs2[15:0]}}, be = a[1] ? 4'b1100 : 4'b0011, misaligned if a[0].
  - word (010): wdata = rs2, be = 4'b1111, misaligned if a != 0.
  - non-memory ops: be = 0.
- Instruction-misaligned: taken and target[1] = 1.
- Exception priority when several apply: cause 01, then 11, then 10.
- On exception:
  - `mem_exc = 1`;
  - `mem_reg_write`, `mem_mem_write` and `mem_mem_read` are forced to 0;
  - no redirect.
- Redirect:
  - on a capture with `taken & ~instr_misaligned`, `redirect` is 1 and `redirect_pc` = target in the following cycle;
  - otherwise `redirect` is 0.
  - `redirect_pc` holds its last value when `redirect` is 0.
- `mem_valid` update each cycle:
  - capture: `mem_valid` becomes 1;
  - no capture, and the MEM stage consumes (`~mem_stall`): `mem_valid` becomes 0;
  - no capture and `mem_stall`: `mem_valid` is unchanged.
- When `mem_valid & mem_stall`, every `mem_*` output holds.

## Timing
- Latency is one cycle from capture edge to `mem_*` and `redirect`.
- Full throughput: one instruction per cycle when not stalled.
- `ex_ready` is combinational from `mem_valid`/`mem_stall`. There are no combinational paths from `ex_*` data inputs to outputs.
- A redirect is never issued for an instruction still blocked by a stall. It fires only in the cycle after its capture edge, and only once.
- Back-to-back taken branches: the second arrives in the redirect cycle and is squashed. Only the first redirects.
- A stall in the redirect cycle does not stretch or delay the `redirect` pulse.
- Reset (async, any time, including mid-stall or mid-redirect) clears all `mem_*` outputs, `redirect`, `redirect_pc`, `mem_exc` and `mem_exc_cause` to 0. After reset, `ex_ready` is 1.

## Test plan
- BEQ at pc=0x100, imm=0x20, `ex_zero`=1 -> next cycle `redirect`=1, `redirect_pc`=0x120, `mem_valid`=1. Following cycle `redirect`=0.
- JALR at pc=0x200, `ex_alu_result`=0x1235 -> `redirect_pc`=0x1234, `mem_result`=0x204, `mem_exc`=0.
- SH with addr=0x1002, rs2=0xAABBCCDD -> `mem_wdata`=0xCCDDCCDD, `mem_be`=4'b1100.
  - Same with addr=0x1003 -> `mem_exc`=1, cause=11, `mem_mem_write`=0.
- `mem_valid`=1 with `mem_stall` held 3 cycles while `ex_valid`=1 -> `ex_ready`=0 and `mem_*` frozen. Stall release -> next instruction captured the following edge, no duplicates.
- Taken BNE followed immediately by ADD with `ex_valid`=1 in the redirect cycle -> ADD discarded, `mem_valid`=0 the next cycle.
- Assert `rst_n`=0 asynchronously mid-stall with `mem_valid`=1 -> all outputs 0 before the next clock edge. `ex_ready`=1 after release.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary: branch/jump resolution into a one-cycle registered
// redirect, store formatting, alignment checks and valid/ready handshake.
module ex_mem_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic            ex_zero,
    input  logic [XLEN-1:0] ex_rs2_data,
    input  logic [4:0]      ex_rd,
    input  logic [2:0]      ex_funct3,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic            ex_branch,
    input  logic            ex_jal,
    input  logic            ex_jalr,
    input  logic            mem_stall,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_pc,
    output logic [XLEN-1:0] mem_result,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    output logic [4:0]      mem_rd,
    output logic [2:0]      mem_funct3,
    output logic            mem_reg_write,
    output logic            mem_mem_read,
    output logic            mem_mem_write,
    output logic            mem_exc,
    output logic [1:0]      mem_exc_cause
);

    logic            capture;
    logic            taken;
    logic            instr_mis;
    logic            data_mis;
    logic            take_redirect;
    logic            exc;
    logic [1:0]      cause;
    logic [1:0]      a;
    logic [3:0]      be;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] wdata;

    assign ex_ready = ~mem_valid | ~mem_stall;
    // An instruction accepted during the redirect cycle is wrong-path and dropped.
    assign capture  = ex_valid & ex_ready & ~redirect;

    always_comb begin
        taken  = (ex_branch & ex_zero) | ex_jal | ex_jalr;
        target = ex_jalr ? {ex_alu_result[XLEN-1:1], 1'b0} : ex_pc + ex_imm;
        result = (ex_jal | ex_jalr) ? ex_pc + XLEN'(4) : ex_alu_result;
        a        = ex_alu_result[1:0];
        be       = '0;
        wdata    = '0;
        data_mis = 1'b0;
        if (ex_mem_read | ex_mem_write) begin
            case (ex_funct3[1:0])
                2'b00: begin
                    be    = 4'b0001 << a;
                    wdata = {4{ex_rs2_data[7:0]}};
                end
                2'b01: begin
                    be       = a[1] ? 4'b1100 : 4'b0011;
                    wdata    = {2{ex_rs2_data[15:0]}};
                    data_mis = a[0];
                end
                2'b10: begin
                    be       = 4'b1111;
                    wdata    = ex_rs2_data;
                    data_mis = (a != 2'b00);
                end
                default: ;
            endcase
        end
        if (!ex_mem_write) begin
            wdata = '0;
        end
        instr_mis = taken & target[1];
        cause     = 2'b00;
        if (instr_mis) begin
            cause = 2'b01;
        end else if (ex_mem_write & data_mis) begin
            cause = 2'b11;
        end else if (ex_mem_read & data_mis) begin
            cause = 2'b10;
        end
        exc           = (cause != 2'b00);
        take_redirect = capture & taken & ~instr_mis;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect      <= 1'b0;
            redirect_pc   <= '0;
            mem_valid     <= 1'b0;
            mem_pc        <= '0;
            mem_result    <= '0;
            mem_wdata     <= '0;
            mem_be        <= '0;
            mem_rd        <= '0;
            mem_funct3    <= '0;
            mem_reg_write <= 1'b0;
            mem_mem_read  <= 1'b0;
            mem_mem_write <= 1'b0;
            mem_exc       <= 1'b0;
            mem_exc_cause <= '0;
        end else begin
            redirect <= take_redirect;
            if (take_redirect) begin
                redirect_pc <= target;
            end
            if (capture) begin
                mem_valid     <= 1'b1;
                mem_pc        <= ex_pc;
                mem_result    <= result;
                mem_wdata     <= wdata;
                mem_be        <= be;
                mem_rd        <= ex_rd;
                mem_funct3    <= ex_funct3;
                mem_reg_write <= ex_reg_write & ~exc;
                mem_mem_read  <= ex_mem_read & ~exc;
                mem_mem_write <= ex_mem_write & ~exc;
                mem_exc       <= exc;
                mem_exc_cause <= cause;
            end else if (!mem_stall) begin
                mem_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized bench for ex_mem_stage with a behavioural reference model,
// plus directed scenarios with hand-computed expectations.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] ex_pc = '0, ex_imm = '0, ex_alu_result = '0, ex_rs2_data = '0;
    logic        ex_zero = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic [2:0]  ex_funct3 = '0;
    logic        ex_reg_write = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
    logic        ex_branch = 1'b0, ex_jal = 1'b0, ex_jalr = 1'b0;
    logic        mem_stall = 1'b0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_valid;
    logic [31:0] mem_pc, mem_result, mem_wdata;
    logic [3:0]  mem_be;
    logic [4:0]  mem_rd;
    logic [2:0]  mem_funct3;
    logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_exc;
    logic [1:0]  mem_exc_cause;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    ex_mem_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_alu_result(ex_alu_result),
        .ex_zero(ex_zero), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
        .mem_stall(mem_stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_result(mem_result),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rd(mem_rd),
        .mem_funct3(mem_funct3), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_exc(mem_exc), .mem_exc_cause(mem_exc_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: what the EX/MEM boundary must hold.
    bit          m_valid, m_red, m_rw, m_mr, m_mw, m_exc;
    logic [31:0] m_rpc, m_pc, m_res, m_wdata;
    logic [3:0]  m_be;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [1:0]  m_cause;

    always @(posedge clk or negedge rst_n) begin
        int          bytes, off;
        bit          accept, cap, tk, imis, dmis, red_next;
        logic [31:0] tgt;
        logic [1:0]  cz;
        if (!rst_n) begin
            m_valid = 0; m_red = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_exc = 0;
            m_rpc = 0; m_pc = 0; m_res = 0; m_wdata = 0; m_be = 0; m_rd = 0;
            m_f3 = 0; m_cause = 0;
        end else begin
            accept   = ex_valid && (!m_valid || !mem_stall);
            cap      = accept && !m_red;
            red_next = 0;
            if (cap) begin
                tk   = (ex_branch && ex_zero) || ex_jal || ex_jalr;
                tgt  = ex_jalr ? ex_alu_result - (ex_alu_result % 2) : ex_pc + ex_imm;
                imis = tk && ((tgt / 2) % 2 == 1);
                bytes = 1 << ex_funct3[1:0];
                off   = ex_alu_result % 4;
                dmis  = (ex_mem_read || ex_mem_write) && (off % bytes != 0);
                m_be  = (ex_mem_read || ex_mem_write)
                        ? 4'(((1 << bytes) - 1) << (off - off % bytes)) : 4'h0;
                if (!ex_mem_write)   m_wdata = 0;
                else if (bytes == 1) m_wdata = ex_rs2_data[7:0] * 32'h0101_0101;
                else if (bytes == 2) m_wdata = ex_rs2_data[15:0] * 32'h0001_0001;
                else                 m_wdata = ex_rs2_data;
                if (imis)                     cz = 2'd1;
                else if (ex_mem_write && dmis) cz = 2'd3;
                else if (ex_mem_read && dmis)  cz = 2'd2;
                else                           cz = 2'd0;
                m_valid = 1;
                m_pc    = ex_pc;
                m_res   = (ex_jal || ex_jalr) ? ex_pc + 4 : ex_alu_result;
                m_rd    = ex_rd;
                m_f3    = ex_funct3;
                m_exc   = (cz != 0);
                m_cause = cz;
                m_rw    = ex_reg_write && !m_exc;
                m_mr    = ex_mem_read && !m_exc;
                m_mw    = ex_mem_write && !m_exc;
                if (tk && !imis) begin
                    red_next = 1;
                    m_rpc    = tgt;
                end
            end else if (!mem_stall) begin
                m_valid = 0;
            end
            m_red = red_next;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ex_ready", 32'(ex_ready), 32'(!m_valid || !mem_stall));
            chk("mem_valid", 32'(mem_valid), 32'(m_valid));
            chk("redirect", 32'(redirect), 32'(m_red));
            chk("redirect_pc", redirect_pc, m_rpc);
            if (m_valid) begin
                chk("mem_pc", mem_pc, m_pc);
                chk("mem_result", mem_result, m_res);
                chk("mem_wdata", mem_wdata, m_wdata);
                chk("mem_be", 32'(mem_be), 32'(m_be));
                chk("mem_rd", 32'(mem_rd), 32'(m_rd));
                chk("mem_funct3", 32'(mem_funct3), 32'(m_f3));
                chk("mem_reg_write", 32'(mem_reg_write), 32'(m_rw));
                chk("mem_mem_read", 32'(mem_mem_read), 32'(m_mr));
                chk("mem_mem_write", 32'(mem_mem_write), 32'(m_mw));
                chk("mem_exc", 32'(mem_exc), 32'(m_exc));
                chk("mem_exc_cause", 32'(mem_exc_cause), 32'(m_cause));
            end
        end
    end

    task automatic clear_ops();
        ex_valid = 0; ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0;
        ex_branch = 0; ex_jal = 0; ex_jalr = 0; ex_zero = 0;
    endtask

    task automatic set_op(input logic [31:0] pc, imm, alu, rs2, input logic [2:0] f3,
                          input logic rw, mr, mw, br, zero, jal, jalr);
        ex_valid = 1; ex_pc = pc; ex_imm = imm; ex_alu_result = alu; ex_rs2_data = rs2;
        ex_rd = 5'd7; ex_funct3 = f3; ex_reg_write = rw; ex_mem_read = mr;
        ex_mem_write = mw; ex_branch = br; ex_zero = zero; ex_jal = jal; ex_jalr = jalr;
    endtask

    task automatic edge_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inst();
        int k;
        clear_ops();
        k             = $urandom_range(0, 5);
        ex_valid      = ($urandom_range(0, 3) != 0);
        mem_stall     = ($urandom_range(0, 9) < 3);
        ex_pc         = $urandom & 32'hFFFF_FFFC;
        ex_imm        = $urandom_range(0, 255) << 1;
        ex_alu_result = $urandom;
        ex_zero       = 1'($urandom_range(0, 1));
        ex_rs2_data   = $urandom;
        ex_rd         = 5'($urandom);
        ex_funct3     = 3'($urandom);
        case (k)
            0: ex_reg_write = 1;
            1: begin
                ex_mem_read = 1; ex_reg_write = 1;
                ex_funct3 = 3'($urandom_range(0, 4));
                if (ex_funct3 == 3'd3) ex_funct3 = 3'd5;
            end
            2: begin ex_mem_write = 1; ex_funct3 = 3'($urandom_range(0, 2)); end
            3: ex_branch = 1;
            4: begin ex_jal = 1; ex_reg_write = 1; end
            default: begin ex_jalr = 1; ex_reg_write = 1; end
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_ops();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem_valid", 32'(mem_valid), 32'd0);
        chk("reset_ex_ready", 32'(ex_ready), 32'd1);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // BEQ taken
        edge_drive();
        set_op(32'h100, 32'h20, 32'h0, 32'h0, 3'd0, 0, 0, 0, 1, 1, 0, 0);
        edge_drive(); clear_ops();
        @(negedge clk);
        chk("beq_redirect", 32'(redirect), 32'd1);
        chk("beq_redirect_pc", redirect_pc, 32'h120);
        chk("beq_mem_valid", 32'(mem_valid), 32'd1);
        @(negedge clk);
        chk("beq_redirect_pulse", 32'(redirect), 32'd0);

        // JALR
        edge_drive();
        set_op(32'h200, 32'h0, 32'h1235, 32'h0, 3'd0, 1, 0, 0, 0, 0, 0, 1);
        edge_drive(); clear_ops();
        @(negedge clk);
        chk("jalr_redirect_pc", redirect_pc, 32'h1234);
        chk("jalr_mem_result", mem_result, 32'h204);
        chk("jalr_mem_exc", 32'(mem_exc), 32'd0);

        // SH aligned then misaligned
        edge_drive(); edge_drive();
        set_op(32'h300, 32'h0, 32'h1002, 32'hAABBCCDD, 3'd1, 0, 0, 1, 0, 0, 0, 0);
        edge_drive(); clear_ops();
        @(negedge clk);
        chk("sh_wdata", mem_wdata, 32'hCCDDCCDD);
        chk("sh_be", 32'(mem_be), 32'hC);
        chk("sh_mem_write", 32'(mem_mem_write), 32'd1);
        edge_drive();
        set_op(32'h304, 32'h0, 32'h1003, 32'hAABBCCDD, 3'd1, 0, 0, 1, 0, 0, 0, 0);
        edge_drive(); clear_ops();
        @(negedge clk);
        chk("sh_mis_exc", 32'(mem_exc), 32'd1);
        chk("sh_mis_cause", 32'(mem_exc_cause), 32'd3);
        chk("sh_mis_mem_write", 32'(mem_mem_write), 32'd0);

        // Stall hold for three cycles, then release
        edge_drive();
        set_op(32'h400, 32'h0, 32'h55, 32'h0, 3'd0, 1, 0, 0, 0, 0, 0, 0);
        edge_drive();
        mem_stall = 1;
        set_op(32'h404, 32'h0, 32'h66, 32'h0, 3'd0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ex_ready", 32'(ex_ready), 32'd0);
            chk("stall_mem_result", mem_result, 32'h55);
            chk("stall_mem_pc", mem_pc, 32'h400);
            if (i < 2) edge_drive();
        end
        edge_drive();
        mem_stall = 0;
        edge_drive(); clear_ops();
        @(negedge clk);
        chk("release_mem_result", mem_result, 32'h66);
        chk("release_mem_valid", 32'(mem_valid), 32'd1);
        @(negedge clk);
        chk("release_no_dup", 32'(mem_valid), 32'd0);

        // Taken BNE then ADD in redirect cycle
        edge_drive();
        set_op(32'h500, 32'h40, 32'h1, 32'h0, 3'd1, 0, 0, 0, 1, 1, 0, 0);
        edge_drive();
        set_op(32'h504, 32'h0, 32'h77, 32'h0, 3'd0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("bne_redirect", 32'(redirect), 32'd1);
        chk("bne_redirect_pc", redirect_pc, 32'h540);
        edge_drive(); clear_ops();
        @(negedge clk);
        chk("squash_mem_valid", 32'(mem_valid), 32'd0);
        chk("squash_redirect", 32'(redirect), 32'd0);

        // Async reset mid-stall
        edge_drive();
        set_op(32'h600, 32'h0, 32'h88, 32'h0, 3'd0, 1, 0, 0, 0, 0, 0, 0);
        edge_drive(); clear_ops();
        mem_stall = 1;
        #2;
        rst_n = 0;
        #1;
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_result", mem_result, 32'd0);
        chk("rst_mem_pc", mem_pc, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_mem_reg_write", 32'(mem_reg_write), 32'd0);
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        #1;
        rst_n = 1;
        mem_stall = 0;

        for (int n = 0; n < 3000; n++) begin
            edge_drive();
            rand_inst();
        end
        edge_drive();
        clear_ops();
        mem_stall = 0;
        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
